// File: rtl/coax_pkg.sv
// -----------------------------------------------------------------------------
// coax_pkg
//   Shared definitions for the coax receive path: receiver error codes,
//   receive-FIFO entry layout and the coax_rx_fifo FSM state encodings.
// -----------------------------------------------------------------------------
package coax_pkg;

    localparam int unsigned DATA_W  = 10;
    localparam int unsigned ENTRY_W = 12;
    localparam int unsigned STAT_W  = 16;

    // FIFO entry field positions: {error, first, data[9:0]}
    localparam int unsigned ERR_BIT   = 11;
    localparam int unsigned FIRST_BIT = 10;
    localparam int unsigned DATA_MSB  = 9;
    localparam int unsigned DATA_LSB  = 0;

    // coax_rx error codes, carried in the data field of an error entry
    localparam logic [DATA_W-1:0] ERR_LOSS_OF_MID_BIT = 10'h001;
    localparam logic [DATA_W-1:0] ERR_PARITY          = 10'h002;
    localparam logic [DATA_W-1:0] ERR_END_SEQ         = 10'h004;
    localparam logic [DATA_W-1:0] ERR_OVERFLOW        = 10'h008;

    // coax_rx_fifo FSM states
    localparam int unsigned STATE_W = 3;
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ACK_HIGH = 3'd1;
    localparam logic [2:0] ST_ACK_WAIT = 3'd2;
    localparam logic [2:0] ST_ERR_PUSH = 3'd3;
    localparam logic [2:0] ST_ERR_RST  = 3'd4;
    localparam logic [2:0] ST_ERR_WAIT = 3'd5;

    typedef struct packed {
        logic              err;
        logic              first;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/coax_fifo.sv
// -----------------------------------------------------------------------------
// coax_fifo
//   Generic synchronous show-ahead FIFO. The head entry is presented on
//   rdata_o whenever the FIFO is not empty; pop_i advances past it.
// Ports
//   clk, reset   clock, synchronous active-high reset
//   push_i       write wdata_i (ignored while full, even with a same-cycle pop)
//   pop_i        discard head entry (ignored while empty)
//   flush_i      empty the FIFO; overrides same-cycle push and pop
//   wdata_i      entry to write
//   rdata_o      head entry (undefined while empty)
//   count_o      occupancy 0..DEPTH
//   full_o       count_o == DEPTH
//   empty_o      count_o == 0
// -----------------------------------------------------------------------------
module coax_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push_c, do_pop_c;

    assign do_push_c = push_i && !full_q;
    assign do_pop_c  = pop_i && !empty_q;

    // Pointer / occupancy update; pointers wrap naturally since DEPTH is 2^n
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push_c, do_pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CNT_W'(DEPTH));
            empty_q  <= (count_d == '0);
        end
    end

    // Storage needs no reset: contents are only observed while not empty
    always_ff @(posedge clk) begin
        if (do_push_c && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/coax_rx_fifo.sv
// -----------------------------------------------------------------------------
// coax_rx_fifo
//   Drains coax_rx words and error codes through the data_available/read
//   handshake into a show-ahead FIFO. The first word of each message is tagged;
//   after an error an error entry is pushed and coax_rx gets a one-cycle reset.
// Ports
//   clk, reset          clock, synchronous active-high reset
//   rx_data             coax_rx data word or error code
//   rx_data_available   coax_rx word ready
//   rx_active           coax_rx receiving a message (rise marks a new message)
//   rx_error            coax_rx in (sticky) error state
//   rx_read             one-cycle read strobe; its falling edge acks the word
//   rx_reset            one-cycle reset pulse to coax_rx after an error
//   flush               discard all FIFO contents
//   fifo_read           pop strobe
//   fifo_data           head entry {error, first, data[9:0]}
//   fifo_empty/full     occupancy flags
//   fifo_count          occupancy 0..DEPTH
//   word_count          data entries pushed (saturating)
//   error_count         error entries pushed (saturating)
// Configuration
//   COAX_RX_FIFO_STATS_EN  build the statistics counters; otherwise
//                          word_count/error_count are tied to 0.
// -----------------------------------------------------------------------------
module coax_rx_fifo
    import coax_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       rx_data,
    input  logic                    rx_data_available,
    input  logic                    rx_active,
    input  logic                    rx_error,
    output logic                    rx_read,
    output logic                    rx_reset,
    input  logic                    flush,
    input  logic                    fifo_read,
    output logic [ENTRY_W-1:0]      fifo_data,
    output logic                    fifo_empty,
    output logic                    fifo_full,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic [STAT_W-1:0]       word_count,
    output logic [STAT_W-1:0]       error_count
);

    logic [STATE_W-1:0] state_q, state_d;
    logic               rx_read_q, rx_read_d;
    logic               rx_reset_q, rx_reset_d;
    logic [DATA_W-1:0]  code_q, code_d;
    logic               first_pending_q, first_pending_d;
    logic               rx_active_q;

    logic               push_c;
    logic               data_push_c;
    logic               err_entry_c;
    logic               rx_active_rise_c;
    fifo_entry_t        push_entry_c;

    assign rx_active_rise_c = rx_active && !rx_active_q;

    // Handshake / error-recovery FSM
    always_comb begin
        state_d      = state_q;
        rx_read_d    = 1'b0;
        rx_reset_d   = 1'b0;
        code_d       = code_q;
        push_c       = 1'b0;
        data_push_c  = 1'b0;
        err_entry_c  = 1'b0;
        push_entry_c = '{err: 1'b0, first: first_pending_q, data: rx_data};

        case (state_q)
            ST_IDLE: begin
                if (rx_error) begin
                    code_d      = rx_data;
                    err_entry_c = 1'b1;
                    state_d     = ST_ERR_PUSH;
                end else if (rx_data_available && !fifo_full) begin
                    push_c      = 1'b1;
                    data_push_c = 1'b1;
                    rx_read_d   = 1'b1;
                    state_d     = ST_ACK_HIGH;
                end
            end
            ST_ACK_HIGH: begin
                state_d = ST_ACK_WAIT;
            end
            // Wait for coax_rx to withdraw the word so it is not captured twice
            ST_ACK_WAIT: begin
                if (!rx_data_available) state_d = ST_IDLE;
            end
            ST_ERR_PUSH: begin
                if (!fifo_full) begin
                    push_c       = 1'b1;
                    push_entry_c = '{err: 1'b1, first: 1'b0, data: code_q};
                    rx_reset_d   = 1'b1;
                    state_d      = ST_ERR_RST;
                end
            end
            ST_ERR_RST: begin
                state_d = ST_ERR_WAIT;
            end
            ST_ERR_WAIT: begin
                if (!rx_error) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // First-word tag: a new message rise outranks a same-cycle push, error wins
    always_comb begin
        first_pending_d = first_pending_q;
        if (data_push_c)      first_pending_d = 1'b0;
        if (rx_active_rise_c) first_pending_d = 1'b1;
        if (err_entry_c)      first_pending_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            rx_read_q       <= 1'b0;
            rx_reset_q      <= 1'b0;
            code_q          <= '0;
            first_pending_q <= 1'b0;
            rx_active_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            rx_read_q       <= rx_read_d;
            rx_reset_q      <= rx_reset_d;
            code_q          <= code_d;
            first_pending_q <= first_pending_d;
            rx_active_q     <= rx_active;
        end
    end

    assign rx_read  = rx_read_q;
    assign rx_reset = rx_reset_q;

    coax_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_c),
        .pop_i   (fifo_read),
        .flush_i (flush),
        .wdata_i (push_entry_c),
        .rdata_o (fifo_data),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef COAX_RX_FIFO_STATS_EN
    // Saturating push statistics; a push discarded by flush is not counted
    logic [STAT_W-1:0] word_count_q, word_count_d;
    logic [STAT_W-1:0] error_count_q, error_count_d;

    always_comb begin
        word_count_d  = word_count_q;
        error_count_d = error_count_q;
        if (push_c && !flush) begin
            if (push_entry_c.err) begin
                if (error_count_q != '1) error_count_d = error_count_q + STAT_W'(1);
            end else begin
                if (word_count_q != '1) word_count_d = word_count_q + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_count_q  <= '0;
            error_count_q <= '0;
        end else begin
            word_count_q  <= word_count_d;
            error_count_q <= error_count_d;
        end
    end

    assign word_count  = word_count_q;
    assign error_count = error_count_q;
`else
    assign word_count  = '0;
    assign error_count = '0;
`endif

endmodule

// File: tb/tb_coax_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_coax_rx_fifo
//   Self-checking bench for coax_rx_fifo. Emulates coax_rx (handshake, error,
//   reset response) and keeps a queue-based reference of the FIFO contents.
// -----------------------------------------------------------------------------
module tb_coax_rx_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [9:0]    rx_data;
    logic          rx_data_available;
    logic          rx_active;
    logic          rx_error;
    logic          rx_read;
    logic          rx_reset;
    logic          flush;
    logic          fifo_read;
    logic [11:0]   fifo_data;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic [15:0]   word_count;
    logic [15:0]   error_count;

    coax_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .rx_data           (rx_data),
        .rx_data_available (rx_data_available),
        .rx_active         (rx_active),
        .rx_error          (rx_error),
        .rx_read           (rx_read),
        .rx_reset          (rx_reset),
        .flush             (flush),
        .fifo_read         (fifo_read),
        .fifo_data         (fifo_data),
        .fifo_empty        (fifo_empty),
        .fifo_full         (fifo_full),
        .fifo_count        (fifo_count),
        .word_count        (word_count),
        .error_count       (error_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state
    logic [11:0] mq[$];
    bit          first_flag;
    int          words_pushed;
    int          errs_pushed;

    // High-cycle counters for the two strobes (one pulse == one high cycle)
    int read_hi  = 0;
    int reset_hi = 0;
    always @(negedge clk) begin
        if (rx_read)  read_hi  <= read_hi + 1;
        if (rx_reset) reset_hi <= reset_hi + 1;
    end

    int          r0;
    int          nw;
    logic [9:0]  d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_fifo(input string tag);
        chk({tag, ".count"}, 32'(fifo_count), 32'(mq.size()));
        chk({tag, ".empty"}, 32'(fifo_empty), 32'(mq.size() == 0));
        chk({tag, ".full"},  32'(fifo_full),  32'(mq.size() == DEPTH));
        if (mq.size() != 0) chk({tag, ".head"}, 32'(fifo_data), 32'(mq[0]));
`ifdef COAX_RX_FIFO_STATS_EN
        chk({tag, ".words"}, 32'(word_count),  32'(words_pushed));
        chk({tag, ".errs"},  32'(error_count), 32'(errs_pushed));
`else
        chk({tag, ".words"}, 32'(word_count),  32'd0);
        chk({tag, ".errs"},  32'(error_count), 32'd0);
`endif
    endtask

    task automatic model_push_word(input logic [9:0] w);
        mq.push_back({1'b0, first_flag, w});
        first_flag = 1'b0;
        words_pushed++;
    endtask

    task automatic word_begin(input logic [9:0] w);
        rx_data           = w;
        rx_data_available = 1'b1;
    endtask

    // Called at the negedge after the capturing edge: read pulse, then withdraw
    task automatic word_end(input int hold);
        chk("rx_read_hi", 32'(rx_read), 32'd1);
        tick();
        chk("rx_read_lo", 32'(rx_read), 32'd0);
        repeat (hold) tick();
        rx_data_available = 1'b0;
        tick();
    endtask

    task automatic send_word(input logic [9:0] w, input int hold);
        word_begin(w);
        tick();
        model_push_word(w);
        word_end(hold);
    endtask

    task automatic pop_one();
        fifo_read = 1'b1;
        tick();
        fifo_read = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 1 && mq.size() > 0; i++) begin
            pop_one();
            chk_fifo(tag);
        end
    endtask

    task automatic do_error(input logic [9:0] code);
        int  base;
        bit  seen;
        base = reset_hi;
        seen = 1'b0;
        rx_data  = code;
        rx_error = 1'b1;
        tick();
        rx_data = ~code;   // code must already be latched
        for (int i = 0; i < 8 && !seen; i++) begin
            if (rx_reset) seen = 1'b1;
            else tick();
        end
        chk("rx_reset_seen", 32'(seen), 32'd1);
        mq.push_back({1'b1, 1'b0, code});
        errs_pushed++;
        first_flag = 1'b0;
        rx_error   = 1'b0;  // coax_rx leaves error state when reset
        tick();
        tick();
        chk("rx_reset_pulses", 32'(reset_hi - base), 32'd1);
        chk_fifo("err");
    endtask

    initial begin
        reset = 1'b1; rx_data = '0; rx_data_available = 1'b0; rx_active = 1'b0;
        rx_error = 1'b0; flush = 1'b0; fifo_read = 1'b0;
        first_flag = 1'b0; words_pushed = 0; errs_pushed = 0;
        @(negedge clk);
        tick();
        tick();
        chk("rst.rx_read",  32'(rx_read),  32'd0);
        chk("rst.rx_reset", 32'(rx_reset), 32'd0);
        chk_fifo("rst");
        reset = 1'b0;
        tick();

        // 1: three-word message, first tag only on the first word
        r0 = read_hi;
        rx_active = 1'b1; tick(); first_flag = 1'b1;
        send_word(10'h155, 0); chk_fifo("msg1");
        chk("msg1.first_entry", 32'(fifo_data), 32'h555);
        send_word(10'h2AA, 0); chk_fifo("msg2");
        send_word(10'h001, 0); chk_fifo("msg3");
        rx_active = 1'b0; tick();
        chk("msg.read_pulses", 32'(read_hi - r0), 32'd3);
        drain("msg_drain");

        // 2: data_available held 4 extra cycles after the ack
        r0 = read_hi;
        send_word(10'h0F0, 4);
        chk("hold.read_pulses", 32'(read_hi - r0), 32'd1);
        chk_fifo("hold");

        // 3: error with code PARITY; pending first tag must be dropped
        rx_active = 1'b1; tick(); first_flag = 1'b1;
        do_error(10'h002);
        send_word(10'h0AB, 0); chk_fifo("post_err");
        rx_active = 1'b0; tick();
        drain("err_drain");

        // 4: fill to DEPTH, 17th word held off until a pop
        rx_active = 1'b1; tick(); first_flag = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            send_word(10'($urandom), 0);
        end
        chk_fifo("filled");
        r0 = read_hi;
        d = 10'($urandom);
        word_begin(d);
        repeat (3) tick();
        chk("full.no_read", 32'(read_hi - r0), 32'd0);
        chk_fifo("full_hold");
        pop_one();
        chk("full.pop_read", 32'(rx_read), 32'd0);
        chk_fifo("full_pop");
        tick();
        model_push_word(d);
        word_end(0);
        chk_fifo("full_refill");
        rx_active = 1'b0; tick();
        drain("full_drain");

        // 5: push+pop at count 5, then pop while empty
        for (int i = 0; i < 5; i++) send_word(10'($urandom), 0);
        chk_fifo("five");
        d = 10'($urandom);
        word_begin(d);
        fifo_read = 1'b1;
        tick();
        fifo_read = 1'b0;
        void'(mq.pop_front());
        model_push_word(d);
        chk_fifo("pushpop");
        word_end(0);
        drain("five_drain");
        pop_one();
        chk_fifo("empty_pop");
        send_word(10'h3C3, 0); chk_fifo("after_empty_pop");

        // Randomized messages with pops and occasional errors
        for (int m = 0; m < 24; m++) begin
            rx_active = 1'b1; tick(); first_flag = 1'b1;
            nw = int'($urandom_range(1, 4));
            for (int k = 0; k < nw; k++) begin
                if (mq.size() >= 12 || (mq.size() > 0 && ($urandom % 2) == 1)) begin
                    pop_one();
                    chk_fifo("rnd_pop");
                end
                if (($urandom % 8) == 0) begin
                    do_error(10'($urandom));
                end else begin
                    send_word(10'($urandom), int'($urandom_range(0, 2)));
                    chk_fifo("rnd_word");
                end
            end
            rx_active = 1'b0; tick();
        end
        drain("rnd_drain");

        // 6: flush with a same-cycle push; handshake still completes
        for (int i = 0; i < 3; i++) send_word(10'($urandom), 0);
        word_begin(10'h1FF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        mq.delete();
        chk_fifo("flush");
        word_end(0);
        chk_fifo("flush_done");
        send_word(10'h123, 0); chk_fifo("after_flush");

        // 6: reset while rx_read is high
        word_begin(10'h0CC);
        tick();
        chk("ackhigh.rx_read", 32'(rx_read), 32'd1);
        reset = 1'b1;
        rx_data_available = 1'b0;
        tick();
        mq.delete(); words_pushed = 0; errs_pushed = 0; first_flag = 1'b0;
        chk("midrst.rx_read",  32'(rx_read),  32'd0);
        chk("midrst.rx_reset", 32'(rx_reset), 32'd0);
        chk_fifo("midrst");
        reset = 1'b0;
        tick();
        send_word(10'h2D2, 0); chk_fifo("after_midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
